cpu_sequencer: RTL

Multi-cycle control sequencer for the processor core: steps each instruction through fetch, decode, execute, memory and write-back, and drives the instruction/data memory request handshakes. Consumes the instruction decoder's classification flags (is_load, is_store, is_halt, reg_we) and produces the write enables for PC, IR and register file. Also provides cycle and retired-instruction counters and a bus timeout that halts the core on a hung memory.

---
 rtl/cpu_sequencer_pkg.sv | 28 ++
 rtl/cpu_sequencer_bus_timer.sv | 33 +++
 rtl/cpu_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared state encodings and defaults for the multi-cycle control sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cpu_sequencer_pkg;

    // Raw 3-bit encodings, also usable by benches for state probes.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    // Cycles a memory request may wait for ack before the core gives up.
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_t;

endpackage

// File: rtl/cpu_sequencer_bus_timer.sv
// Wait counter for an outstanding memory request; flags expiry on the last allowed cycle.
// Latency: expired is combinational from the registered count and the current ack.
// Backpressure: none; an ack in the final allowed cycle suppresses expiry.
module bus_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic ack,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] wait_cnt;

    // Count request cycles without ack; idle states and acks restart the count.
    always_ff @(posedge clk) begin
        if (rst || clr || ack) begin
            wait_cnt <= '0;
        end else if (run) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // The TIMEOUT-th request cycle without ack is the expiry cycle; TIMEOUT=0 disables.
    always_comb begin
        expired = (TIMEOUT > 0) && run && !ack && (wait_cnt == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with cycle and retired-instruction counters.
// Latency: ALU op 4 cycles, load 5, store 4 with zero-wait memory; each ack wait adds a cycle.
// Backpressure: imem_req/dmem_req held until ack; a hung bus halts the core after TIMEOUT cycles.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    input  logic             reg_we,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    state_t state;
    state_t state_nxt;
    logic   err_q;
    logic   err_nxt;
    logic   retire;
    logic   req_run;
    logic   req_ack;
    logic   expired;

    // Only the state that owns a request listens to its ack.
    assign req_run = (state == S_FETCH) || (state == S_MEM);
    assign req_ack = ((state == S_FETCH) && imem_ack) || ((state == S_MEM) && dmem_ack);

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!req_run),
        .run     (req_run),
        .ack     (req_ack),
        .expired (expired)
    );

    // State and sticky bus-error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    // Next-state and strobe decode; reset suppresses every strobe and request.
    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        retire    = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        halted    = 1'b0;
        bus_err   = 1'b0;
        unique case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = S_DECODE;
                end else if (expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    retire    = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: state_nxt = (is_load || is_store) ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store && !is_load;
                if (dmem_ack) begin
                    if (is_load) begin
                        state_nxt = S_WB;
                    end else begin
                        pc_we     = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_WB: begin
                rf_we     = reg_we;
                pc_we     = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                bus_err = err_q;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            rf_we    = 1'b0;
            halted   = 1'b0;
            bus_err  = 1'b0;
        end
    end

    // Free-running cycle counter (frozen in HALT) and retire counter; both wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (state != S_HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule
